// File: rtl/time_pkg.sv
// time_pkg: BCD limits, hour bounds and conversion helpers for the time-of-day counter
package time_pkg;
  localparam logic [3:0] MAX_LS = 4'd9;
  localparam logic [3:0] MAX_MS_MINSEC = 4'd5;
  localparam logic [6:0] H24_MAX = 7'd23;
  localparam logic [6:0] H12_MIN = 7'd1;
  localparam logic [6:0] H12_MAX = 7'd12;
  typedef logic [3:0] bcd_digit_t;
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } hhmmss_t;
  function automatic logic [6:0] bcd2bin(input logic [7:0] h);
    return 7'(h[7:4]) * 7'd10 + 7'(h[3:0]);
  endfunction
  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction
endpackage

// File: rtl/bcd_digit_ctr.sv
// bcd_digit_ctr: one BCD digit with load, increment and runtime wrap bounds
module bcd_digit_ctr
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  bcd_digit_t max,
  input  bcd_digit_t min,
  output bcd_digit_t q,
  output logic       carry
);
  assign carry = inc && q == max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= load_val;
    else if (inc) q <= carry ? min : q + 4'd1;
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HH:MM[:SS] BCD time-of-day counter with 12h/24h mode and validated loads
module bcd_time_counter
  import time_pkg::*;
#(
  parameter bit         WITH_SECONDS = 1'b0,
  parameter logic [7:0] RESET_HOUR   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load_new_c,
  input  logic [15:0] new_current_time,
  input  logic [7:0]  new_seconds,
  input  logic        new_pm,
  input  logic        mode_12h,
  output logic [15:0] current_time,
  output logic [7:0]  seconds,
  output logic        pm,
  output logic        day_rollover,
  output logic        load_err
);
  hhmmss_t nt;
  logic mode_q, pending, valid, accept, conv, adv, c_sec, c_ls_min, hour_inc, roll;
  logic min_ok, sec_ok, hour_ok;
  bcd_digit_t ls_min, ms_min;
  logic [6:0] hb, nb, h12, h24;
  logic [7:0] hh, hh_inc, hh_tick;
  assign nt = '{hh: new_current_time[15:8], mm: new_current_time[7:0], ss: new_seconds};
  always_comb begin
    nb = bcd2bin(nt.hh);
    hb = bcd2bin(hh);
    min_ok = nt.mm[7:4] <= MAX_MS_MINSEC && nt.mm[3:0] <= MAX_LS;
    sec_ok = !WITH_SECONDS || (nt.ss[7:4] <= MAX_MS_MINSEC && nt.ss[3:0] <= MAX_LS);
    hour_ok = nt.hh[7:4] <= MAX_LS && nt.hh[3:0] <= MAX_LS &&
              (mode_12h ? nb >= H12_MIN && nb <= H12_MAX : nb <= H24_MAX);
    valid = min_ok && sec_ok && hour_ok;
    accept = load_new_c && valid;
    conv = !load_new_c && mode_12h != mode_q;
    adv = !load_new_c && !conv && (tick || pending);
    hh_inc = hh[3:0] == MAX_LS ? {hh[7:4] + 4'd1, 4'd0} : {hh[7:4], hh[3:0] + 4'd1};
    hh_tick = !mode_q ? (hb == H24_MAX ? 8'h00 : hh_inc) :
              hb == H12_MAX ? 8'h01 : hb == H12_MAX - 7'd1 ? 8'h12 : hh_inc;
    roll = hour_inc && (mode_q ? hb == H12_MAX - 7'd1 && pm : hb == H24_MAX);
    h12 = hb == 7'd0 ? H12_MAX : hb > H12_MAX ? hb - H12_MAX : hb;
    h24 = hb == H12_MAX ? (pm ? H12_MAX : 7'd0) : pm ? hb + H12_MAX : hb;
  end
  generate
    if (WITH_SECONDS) begin : g_sec
      bcd_digit_t ls_sec, ms_sec;
      logic c_ls_sec;
      bcd_digit_ctr u_ls_sec (.clk, .rst_n, .inc(adv), .load(accept), .load_val(nt.ss[3:0]),
                              .max(MAX_LS), .min(4'd0), .q(ls_sec), .carry(c_ls_sec));
      bcd_digit_ctr u_ms_sec (.clk, .rst_n, .inc(c_ls_sec), .load(accept), .load_val(nt.ss[7:4]),
                              .max(MAX_MS_MINSEC), .min(4'd0), .q(ms_sec), .carry(c_sec));
      assign seconds = {ms_sec, ls_sec};
    end else begin : g_nosec
      assign c_sec = adv;
      assign seconds = 8'h00;
    end
  endgenerate
  bcd_digit_ctr u_ls_min (.clk, .rst_n, .inc(c_sec), .load(accept), .load_val(nt.mm[3:0]),
                          .max(MAX_LS), .min(4'd0), .q(ls_min), .carry(c_ls_min));
  bcd_digit_ctr u_ms_min (.clk, .rst_n, .inc(c_ls_min), .load(accept), .load_val(nt.mm[7:4]),
                          .max(MAX_MS_MINSEC), .min(4'd0), .q(ms_min), .carry(hour_inc));
  assign current_time = {hh, ms_min, ls_min};
  // A rejected load keeps mode_q so a concurrent mode change still converts next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hh <= RESET_HOUR;
      pm <= 1'b0;
      mode_q <= 1'b0;
      pending <= 1'b0;
      day_rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      mode_q <= load_new_c && !valid ? mode_q : mode_12h;
      pending <= conv && tick;
      day_rollover <= roll;
      load_err <= load_new_c && !valid;
      if (accept) begin
        hh <= nt.hh;
        pm <= mode_12h && new_pm;
      end else if (conv) begin
        hh <= bin2bcd(mode_12h ? h12 : h24);
        pm <= mode_12h && hb >= H12_MAX;
      end else if (hour_inc) begin
        hh <= hh_tick;
        pm <= pm ^ (mode_q && hb == H12_MAX - 7'd1);
      end
    end
endmodule
